// File: rtl/layer_scheduler.sv
// Layer scheduler: sequences M neurons through one shared neuron datapath and
// collects each neuron's result into its slice of layer_out.
// Optional watchdog: define SCHED_TIMEOUT_EN to abort a layer whose neuron never
// completes within TMO WAIT cycles. In that case the slice is zeroed and err is set.
module layer_scheduler #(
  parameter int unsigned DW  = 8,
  parameter int unsigned M   = 4,
  parameter int unsigned TMO = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 layer_start,
  input  logic                 hidden_in,
  input  logic                 neuron_ready,
  input  logic [DW-1:0]        neuron_result,
  output logic                 neuron_start,
  output logic                 hidden,
  output logic [$clog2(M)-1:0] widx,
  output logic [DW*M-1:0]      layer_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned IW = $clog2(M);
  localparam logic [IW-1:0] LastIdx = IW'(M - 1);

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StStore, StDone} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   widx_q;
  logic            hidden_q;
  logic [DW*M-1:0] layer_out_q;
  logic [DW-1:0]   res_q;
  logic            ready_q;
  logic            complete;
  logic            timeout;

  // Only a fresh rising edge of ready counts; a level left over from the
  // previous neuron must not complete the current one.
  assign complete = (state_q == StWait) && neuron_ready && !ready_q;

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_q;
  logic          err_q;

  // Abort on the TMO-th WAIT cycle without completion.
  assign timeout = (state_q == StWait) && !complete && (tmo_q == TW'(TMO - 1));
  assign err     = err_q;

  // Watchdog: cleared on entry to WAIT, counts WAIT cycles; err sticky per layer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == StLaunch) begin
        tmo_q <= '0;
      end else if (state_q == StWait) begin
        tmo_q <= tmo_q + TW'(1);
      end
      if (state_q == StIdle && layer_start) begin
        err_q <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO;
  assign timeout    = 1'b0;
  assign err        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (layer_start) state_d = StLaunch;
      StLaunch: state_d = StWait;
      StWait: begin
        if (complete) begin
          state_d = StStore;
        end else if (timeout) begin
          state_d = StDone;
        end
      end
      StStore:  state_d = (widx_q == LastIdx) ? StDone : StLaunch;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath: index, latched mode, ready history, result capture and collection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      widx_q      <= '0;
      hidden_q    <= 1'b0;
      layer_out_q <= '0;
      res_q       <= '0;
      ready_q     <= 1'b0;
    end else begin
      ready_q <= neuron_ready;
      case (state_q)
        StIdle: begin
          if (layer_start) begin
            widx_q   <= '0;
            hidden_q <= hidden_in;
          end
        end
        StWait: begin
          if (complete) begin
            res_q <= neuron_result;
          end else if (timeout) begin
            layer_out_q[DW*widx_q +: DW] <= '0;
          end
        end
        StStore: begin
          layer_out_q[DW*widx_q +: DW] <= res_q;
          if (widx_q != LastIdx) begin
            widx_q <= widx_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are straight decodes of state so reset takes effect immediately.
  always_comb begin
    neuron_start = (state_q == StLaunch);
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
    hidden       = hidden_q;
    widx         = widx_q;
    layer_out    = layer_out_q;
  end

endmodule

// File: tb/tb_layer_scheduler.sv
// Bench for layer_scheduler: a responder plays the shared neuron with per-neuron
// latencies and results; expectations come from those tables.
module tb_layer_scheduler;
  localparam int unsigned DW = 8;
  localparam int unsigned M = 4;
  localparam int unsigned TMO = 64;
  localparam int HOLD = -1;  // ready held high into WAIT, low 2 cycles, then high
  localparam int HOLD_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic layer_start = 1'b0;
  logic hidden_in = 1'b0;
  logic neuron_ready = 1'b0;
  logic [DW-1:0] neuron_result = '0;
  logic neuron_start, hidden, busy, done, err;
  logic [$clog2(M)-1:0] widx;
  logic [DW*M-1:0] layer_out;

  layer_scheduler #(.DW(DW), .M(M), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .layer_start(layer_start), .hidden_in(hidden_in),
    .neuron_ready(neuron_ready), .neuron_result(neuron_result),
    .neuron_start(neuron_start), .hidden(hidden), .widx(widx),
    .layer_out(layer_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0, done_cnt = 0, busy_cnt = 0, hid_bad = 0;
  bit exp_hidden = 1'b0;
  int lat_tbl[M];
  logic [DW-1:0] res_tbl[M];
  int resp_idx = 0;
  logic [DW*M-1:0] exp_out = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Event monitor: counts pulses and busy cycles, flags hidden changes while busy.
  always @(negedge clk) begin
    if (neuron_start) start_cnt <= start_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (busy && hidden !== exp_hidden) hid_bad <= hid_bad + 1;
  end

  // Neuron responder: ready rises so that it is high in WAIT cycle lat_tbl[k].
  initial begin
    forever begin
      @(negedge clk);
      if (neuron_start && rst && resp_idx < M) begin
        int k;
        k = resp_idx;
        resp_idx++;
        if (lat_tbl[k] == HOLD) begin
          neuron_result = 8'hEE;
          @(posedge clk);
          @(posedge clk);
          #1 neuron_ready = 1'b0;
          @(posedge clk);
          @(posedge clk);
          #1 neuron_ready = 1'b1;
          neuron_result = res_tbl[k];
        end else begin
          neuron_ready = 1'b0;
          @(posedge clk);
          if (lat_tbl[k] > 0) begin
            repeat (lat_tbl[k] - 1) @(posedge clk);
            #1 neuron_ready = 1'b1;
            neuron_result = res_tbl[k];
          end
        end
      end
    end
  end

  function automatic int exp_busy(input int upto);
    int s = 1;
    for (int i = 0; i < upto; i++) s += 2 + ((lat_tbl[i] == HOLD) ? HOLD_WAIT : lat_tbl[i]);
    return s;
  endfunction

  function automatic logic [DW*M-1:0] all_results();
    logic [DW*M-1:0] v;
    for (int i = 0; i < M; i++) v[i*DW +: DW] = res_tbl[i];
    return v;
  endfunction

  // mode 0: plain, 1: re-pulse layer_start in WAIT of neuron 1, 2: toggle hidden_in there.
  task automatic run_layer(input bit hid, input int mode, input int budget,
                           output int sd, output int dd, output int bd, output int hb);
    int s0, d0, b0, h0, launches, phase;
    resp_idx = 0;
    exp_hidden = hid;
    @(negedge clk);
    #1;
    s0 = start_cnt; d0 = done_cnt; b0 = busy_cnt; h0 = hid_bad;
    launches = 0;
    phase = 0;
    layer_start = 1'b1;
    hidden_in = hid;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == 0) begin
        layer_start = 1'b0;
        chk("widx_at_first_launch", widx, 0);
      end
      if (neuron_start) launches++;
      case (phase)
        0: if (mode != 0 && launches == 2 && neuron_start) phase = 1;
        1: begin
          if (mode == 1) layer_start = 1'b1;
          else hidden_in = ~hidden_in;
          phase = 2;
        end
        2: begin
          layer_start = 1'b0;
          phase = 3;
        end
        default: ;
      endcase
      #1;
      if (done_cnt != d0) break;
    end
    layer_start = 1'b0;
    @(negedge clk);
    #1;
    sd = start_cnt - s0; dd = done_cnt - d0; bd = busy_cnt - b0; hb = hid_bad - h0;
  endtask

  task automatic check_layer(input string tag, input int sd, input int dd, input int bd,
                             input int hb, input int eb, input int es, input int ed,
                             input logic ee, input int ew);
    chk({tag, ".layer_out"}, layer_out, exp_out);
    chk({tag, ".starts"}, sd, es);
    chk({tag, ".dones"}, dd, ed);
    chk({tag, ".busy_cycles"}, bd, eb);
    chk({tag, ".busy_after"}, busy, 0);
    chk({tag, ".widx_hold"}, widx, ew);
    chk({tag, ".hidden"}, hidden, exp_hidden);
    chk({tag, ".err"}, err, ee);
    chk({tag, ".hidden_stable"}, hb, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".neuron_start"}, neuron_start, 0);
    chk({tag, ".widx"}, widx, 0);
    chk({tag, ".hidden"}, hidden, 0);
    chk({tag, ".layer_out"}, layer_out, 0);
    chk({tag, ".err"}, err, 0);
  endtask

  initial begin
    int sd, dd, bd, hb, d0, launches;
    bit hid;
    for (int i = 0; i < M; i++) begin
      lat_tbl[i] = 5;
      res_tbl[i] = '0;
    end

    // Reset state.
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Fixed latency 5, results 11..44.
    for (int i = 0; i < M; i++) res_tbl[i] = DW'((i + 1) * 8'h11);
    run_layer(1'b0, 0, 200, sd, dd, bd, hb);
    exp_out = all_results();
    chk("basic.packed_value", layer_out, 32'h44332211);
    check_layer("basic", sd, dd, bd, hb, 4 * (2 + 5) + 1, M, 1, 1'b0, M - 1);

    // Stale ready level carried into WAIT of neuron 1.
    lat_tbl = '{3, HOLD, 2, 5};
    res_tbl = '{8'h13, 8'h5A, 8'h77, 8'h81};
    run_layer(1'b0, 0, 200, sd, dd, bd, hb);
    exp_out = all_results();
    check_layer("stale_ready", sd, dd, bd, hb, exp_busy(M), M, 1, 1'b0, M - 1);

    // layer_start while busy is ignored.
    lat_tbl = '{2, 4, 3, 1};
    for (int i = 0; i < M; i++) res_tbl[i] = DW'($urandom_range(0, 255));
    run_layer(1'b0, 1, 200, sd, dd, bd, hb);
    exp_out = all_results();
    check_layer("busy_start", sd, dd, bd, hb, exp_busy(M), M, 1, 1'b0, M - 1);
    repeat (3) @(negedge clk);
    #1;
    chk("busy_start.no_queued_layer", busy, 0);

    // hidden latched at start, hidden_in toggled mid-layer.
    lat_tbl = '{3, 3, 2, 6};
    for (int i = 0; i < M; i++) res_tbl[i] = DW'($urandom_range(0, 255));
    run_layer(1'b1, 2, 200, sd, dd, bd, hb);
    exp_out = all_results();
    check_layer("hidden_latch", sd, dd, bd, hb, exp_busy(M), M, 1, 1'b0, M - 1);

    // Randomised layers.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < M; i++) begin
        lat_tbl[i] = $urandom_range(1, 8);
        res_tbl[i] = DW'($urandom_range(0, 255));
      end
      hid = 1'($urandom_range(0, 1));
      run_layer(hid, 0, 300, sd, dd, bd, hb);
      exp_out = all_results();
      check_layer($sformatf("random%0d", r), sd, dd, bd, hb, exp_busy(M), M, 1, 1'b0, M - 1);
    end

    // Asynchronous reset during WAIT of neuron 2.
    lat_tbl = '{3, 3, 20, 3};
    for (int i = 0; i < M; i++) res_tbl[i] = DW'($urandom_range(1, 255));
    resp_idx = 0;
    exp_hidden = 1'b1;
    @(negedge clk);
    #1;
    d0 = done_cnt;
    layer_start = 1'b1;
    hidden_in = 1'b1;
    launches = 0;
    for (int c = 0; c < 200 && launches < 3; c++) begin
      @(negedge clk);
      layer_start = 1'b0;
      if (neuron_start) launches++;
    end
    chk("mid_reset.launches_before", launches, 3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    chk("mid_reset.no_done", done_cnt, d0);
    exp_out = '0;
    lat_tbl = '{2, 5, 1, 3};
    for (int i = 0; i < M; i++) res_tbl[i] = DW'($urandom_range(0, 255));
    run_layer(1'b0, 0, 200, sd, dd, bd, hb);
    exp_out = all_results();
    check_layer("after_reset", sd, dd, bd, hb, exp_busy(M), M, 1, 1'b0, M - 1);

    // Neuron 1 never completes.
    lat_tbl = '{4, 0, 3, 3};
    res_tbl[0] = 8'hC3;
    run_layer(1'b0, 0, 200, sd, dd, bd, hb);
`ifdef SCHED_TIMEOUT_EN
    exp_out[0 +: DW] = 8'hC3;
    exp_out[DW +: DW] = '0;
    check_layer("timeout", sd, dd, bd, hb, (2 + 4) + 1 + TMO + 1, 2, 1, 1'b1, 1);
    lat_tbl = '{2, 2, 2, 2};
    for (int i = 0; i < M; i++) res_tbl[i] = DW'($urandom_range(0, 255));
    run_layer(1'b0, 0, 200, sd, dd, bd, hb);
    exp_out = all_results();
    check_layer("after_timeout", sd, dd, bd, hb, exp_busy(M), M, 1, 1'b0, M - 1);
`else
    chk("stall.still_busy", busy, 1);
    chk("stall.no_done", dd, 0);
    chk("stall.starts", sd, 2);
    chk("stall.err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("stall_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
